ascii_seq_feeder: RTL and testbench

- Stimulus-side partner of the character-classification verifier: plays a stored ASCII string into the verifier's ascii_char/char_valid input, framed as NUL, payload, NUL.
- Collects the verifier's verdict from its sequence_valid/output_strobe pair, with a timeout.
- Sits between host/UART-RX write logic (which loads the string) and the verifier; pass/timeout feed the board LEDs and the reporter.

---
 rtl/ascii_feeder_pkg.sv | 5 +
 rtl/feeder_str_ram.sv | 17 +
 rtl/ascii_seq_feeder.sv | 128 ++++++++++++
 tb/tb_ascii_seq_feeder.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/ascii_feeder_pkg.sv
// ascii_feeder_pkg: FSM state encoding and framing constant shared by the feeder block.
package ascii_feeder_pkg;
  typedef enum logic [2:0] {IDLE, EMIT, GAP, WAIT, REPORT} state_t;
  localparam logic [7:0] ASCII_NUL = 8'h00;
endpackage

// File: rtl/feeder_str_ram.sv
// feeder_str_ram: string buffer, synchronous write, asynchronous read.
module feeder_str_ram #(
  parameter int DEPTH = 32,
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [7:0]    i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [7:0]    o_rdata
);
  logic [7:0] r_mem [DEPTH];
  always_ff @(posedge clk)
    if (i_we) r_mem[i_waddr] <= i_wdata;
  assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/ascii_seq_feeder.sv
// ascii_seq_feeder: plays a NUL-framed string into the verifier and collects its verdict with a timeout.
// ASCII_FEEDER_LOOP_EN: auto-restart after each report and add the saturating fail_cnt output.
module ascii_seq_feeder
  import ascii_feeder_pkg::*;
#(
  parameter int MAX_LEN = 32,
  parameter int GAP = 4,
  parameter int TIMEOUT = 4096
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       wr_en,
  input  logic [$clog2(MAX_LEN)-1:0] wr_addr,
  input  logic [7:0]                 wr_data,
  input  logic [$clog2(MAX_LEN):0]   str_len,
  output logic [7:0]                 ascii_char,
  output logic                       char_valid,
  input  logic                       sequence_valid,
  input  logic                       output_strobe,
  output logic                       busy,
  output logic                       done,
  output logic                       pass,
`ifdef ASCII_FEEDER_LOOP_EN
  output logic                       timeout,
  output logic [15:0]                fail_cnt
`else
  output logic                       timeout
`endif
);
  localparam int AW = $clog2(MAX_LEN);
  localparam int LW = AW + 1;
  localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);
`ifdef ASCII_FEEDER_LOOP_EN
  localparam bit LOOP = 1'b1;
`else
  localparam bit LOOP = 1'b0;
`endif
  state_t r_state, w_next, w_post;
  logic [LW-1:0] r_len, r_pos, w_nxt_pos;
  logic [GW-1:0] r_gcnt;
  logic [TW-1:0] r_tcnt;
  logic [7:0] r_char, w_rdata, w_byte;
  logic r_seen, r_pass, r_timeout;
  logic w_busy, w_hit, w_seen, w_last, w_gap_end, w_tmo, w_run, w_adv;
  feeder_str_ram #(.DEPTH(MAX_LEN), .AW(AW)) u_ram (
    .clk    (clk),
    .i_we   (wr_en && !w_busy),
    .i_waddr(wr_addr),
    .i_wdata(wr_data),
    .i_raddr(r_pos[AW-1:0]),
    .o_rdata(w_rdata)
  );
  assign w_busy = (r_state == EMIT) || (r_state == ascii_feeder_pkg::GAP) || (r_state == WAIT);
  assign w_hit = w_busy && output_strobe && !r_seen;
  assign w_seen = r_seen || w_hit;
  // r_pos is the frame position on the wire: 0 = leading NUL, len+1 = trailing NUL
  assign w_last = (r_pos == r_len + 1'b1);
  assign w_nxt_pos = r_pos + 1'b1;
  assign w_byte = (w_nxt_pos == r_len + 1'b1) ? ASCII_NUL : w_rdata;
  assign w_gap_end = (r_gcnt == GW'(GAP - 1));
  assign w_tmo = (r_state == WAIT) && (r_tcnt == TW'(TIMEOUT - 1));
  always_comb begin
    w_post = w_last ? (w_seen ? REPORT : WAIT) : EMIT;
    w_next = r_state;
    case (r_state)
      IDLE:                  w_next = start ? EMIT : IDLE;
      EMIT:                  w_next = (GAP > 0) ? ascii_feeder_pkg::GAP : w_post;
      ascii_feeder_pkg::GAP: w_next = w_gap_end ? w_post : ascii_feeder_pkg::GAP;
      WAIT:                  w_next = (output_strobe || w_tmo) ? REPORT : WAIT;
      REPORT:                w_next = LOOP ? EMIT : IDLE;
      default:               w_next = IDLE;
    endcase
  end
  assign w_run = (w_next == EMIT) && ((r_state == IDLE) || (r_state == REPORT));
  assign w_adv = (w_next == EMIT) && !w_run;
  always_ff @(posedge clk)
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  always_ff @(posedge clk)
    if (rst) begin
      r_len     <= '0;
      r_pos     <= '0;
      r_char    <= ASCII_NUL;
      r_gcnt    <= '0;
      r_tcnt    <= '0;
      r_seen    <= 1'b0;
      r_pass    <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_gcnt <= (r_state == ascii_feeder_pkg::GAP) ? r_gcnt + 1'b1 : '0;
      r_tcnt <= (r_state == WAIT) ? r_tcnt + 1'b1 : '0;
      if (w_run) begin
        if (r_state == IDLE) r_len <= (str_len > LW'(MAX_LEN)) ? LW'(MAX_LEN) : str_len;
        r_pos     <= '0;
        r_char    <= ASCII_NUL;
        r_seen    <= 1'b0;
        r_pass    <= 1'b0;
        r_timeout <= 1'b0;
      end else begin
        if (w_adv) begin
          r_pos  <= w_nxt_pos;
          r_char <= w_byte;
        end
        if (w_hit) begin
          r_seen <= 1'b1;
          r_pass <= sequence_valid;
        end else if (w_tmo) begin
          r_timeout <= 1'b1;
          r_pass    <= 1'b0;
        end
      end
    end
`ifdef ASCII_FEEDER_LOOP_EN
  logic [15:0] r_fail_cnt;
  always_ff @(posedge clk)
    if (rst) r_fail_cnt <= '0;
    else if ((r_state == REPORT) && !r_pass && (r_fail_cnt != 16'hFFFF)) r_fail_cnt <= r_fail_cnt + 16'd1;
  assign fail_cnt = r_fail_cnt;
`endif
  assign ascii_char = r_char;
  assign char_valid = (r_state == EMIT);
  assign busy = w_busy;
  assign done = (r_state == REPORT);
  assign pass = r_pass;
  assign timeout = r_timeout;
endmodule

// File: tb/tb_ascii_seq_feeder.sv
// tb_ascii_seq_feeder: scoreboarded bench for ascii_seq_feeder (GAP=4 instance plus a GAP=0 instance).
module tb_ascii_seq_feeder;
  localparam int ML = 8, G = 4, TO = 16;
  typedef struct {int cyc; logic [7:0] ch;} exp_t;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, start0 = 1'b0, wr_en = 1'b0;
  logic sequence_valid = 1'b0, output_strobe = 1'b0, zero = 1'b0;
  logic [2:0] wr_addr = '0;
  logic [7:0] wr_data = '0;
  logic [3:0] str_len = '0;
  logic [7:0] ascii_char, ascii_char0;
  logic char_valid, busy, done, pass, timeout;
  logic char_valid0, busy0, done0, pass0, timeout0;
`ifdef ASCII_FEEDER_LOOP_EN
  logic [15:0] fail_cnt, fail_cnt0;
`endif
  exp_t q[$];
  exp_t e_mon;
  logic [7:0] mem [ML];
  int cyc = 0, n_chk = 0, n_fail = 0, n_done = 0;
  ascii_seq_feeder #(.MAX_LEN(ML), .GAP(G), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .start(start), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .str_len(str_len), .ascii_char(ascii_char), .char_valid(char_valid),
    .sequence_valid(sequence_valid), .output_strobe(output_strobe),
    .busy(busy), .done(done), .pass(pass),
`ifdef ASCII_FEEDER_LOOP_EN
    .fail_cnt(fail_cnt),
`endif
    .timeout(timeout)
  );
  ascii_seq_feeder #(.MAX_LEN(ML), .GAP(0), .TIMEOUT(TO)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .str_len(str_len), .ascii_char(ascii_char0), .char_valid(char_valid0),
    .sequence_valid(zero), .output_strobe(zero),
    .busy(busy0), .done(done0), .pass(pass0),
`ifdef ASCII_FEEDER_LOOP_EN
    .fail_cnt(fail_cnt0),
`endif
    .timeout(timeout0)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, got, exp, cyc);
    end
  endtask
  always @(negedge clk)
    if (!rst) begin
      if (char_valid) begin
        if (q.size() == 0) chk("char_extra", {31'd0, char_valid}, 32'd0);
        else begin
          e_mon = q.pop_front();
          chk("char_val", {24'd0, ascii_char}, {24'd0, e_mon.ch});
          chk("char_cyc", cyc, e_mon.cyc);
        end
      end
      if (done) n_done++;
    end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic to_cyc(input int k);
    while (cyc < k) tick();
  endtask
  task automatic wr(input int a, input logic [7:0] d);
    tick();
    wr_en = 1'b1; wr_addr = 3'(a); wr_data = d; mem[a] = d;
    tick();
    wr_en = 1'b0;
  endtask
  task automatic play(input int len, input bit w, input int a, input logic [7:0] d, output int c);
    tick();
    start = 1'b1; str_len = 4'(len); c = cyc;
    if (w) begin
      wr_en = 1'b1; wr_addr = 3'(a); wr_data = d; mem[a] = d;
    end
    q.push_back('{c + 1, 8'h00});
    for (int i = 0; i < len; i++) q.push_back('{c + 1 + (i + 1) * (G + 1), mem[i]});
    q.push_back('{c + 1 + (len + 1) * (G + 1), 8'h00});
    tick();
    start = 1'b0; wr_en = 1'b0;
  endtask
  task automatic strobe(input int k, input logic v);
    to_cyc(k);
    output_strobe = 1'b1; sequence_valid = v;
    tick();
    output_strobe = 1'b0; sequence_valid = 1'b0;
  endtask
  task automatic finish_run(input string tag, input int exp_at, input logic exp_pass, input logic exp_to, input int d0);
    int at = -1;
    for (int i = 0; i < 80 && at < 0; i++) begin
      @(negedge clk);
      if (done) at = cyc;
    end
    chk({tag, "_done_cyc"}, at, exp_at);
    chk({tag, "_pass"}, {31'd0, pass}, {31'd0, exp_pass});
    chk({tag, "_timeout"}, {31'd0, timeout}, {31'd0, exp_to});
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    tick();
    tick();
    chk({tag, "_done_cnt"}, n_done - d0, 1);
    chk({tag, "_pass_hold"}, {31'd0, pass}, {31'd0, exp_pass});
    chk({tag, "_q_empty"}, q.size(), 0);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int c, d0, at;
    repeat (3) tick();
    @(negedge clk);
    chk("reset", {19'd0, ascii_char, char_valid, busy, done, pass, timeout}, 32'd0);
    chk("reset0", {19'd0, ascii_char0, char_valid0, busy0, done0, pass0, timeout0}, 32'd0);
    tick();
    rst = 1'b0;
    wr(0, "A"); wr(1, "b"); wr(2, "1");
    d0 = n_done;
    play(3, 0, 0, 8'h00, c);
    chk("busy_run", {31'd0, busy}, 32'd1);
    strobe(c + 31, 1'b1);
    finish_run("ab1", c + 32, 1'b1, 1'b0, d0);
    d0 = n_done;
    play(3, 0, 0, 8'h00, c);
    to_cyc(c + 5);
    start = 1'b1; wr_en = 1'b1; wr_addr = 3'd1; wr_data = "Z";
    tick();
    start = 1'b0; wr_en = 1'b0;
    finish_run("tmo", c + 42, 1'b0, 1'b1, d0);
    d0 = n_done;
    play(3, 0, 0, 8'h00, c);
    strobe(c + 41, 1'b1);
    finish_run("strobe_vs_tmo", c + 42, 1'b1, 1'b0, d0);
    wr(0, "H"); wr(1, "E"); wr(2, "L"); wr(3, "L"); wr(4, "O");
    d0 = n_done;
    play(5, 0, 0, 8'h00, c);
    strobe(c + 12, 1'b0);
    strobe(c + 20, 1'b1);
    finish_run("early", c + 36, 1'b0, 1'b0, d0);
    play(5, 0, 0, 8'h00, c);
    to_cyc(c + 18);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mid", {19'd0, ascii_char, char_valid, busy, done, pass, timeout}, 32'd0);
    chk("rst_q_left", q.size(), 3);
    q.delete();
    d0 = n_done;
    play(5, 1, 0, "h", c);
    strobe(c + 3, 1'b1);
    finish_run("replay", c + 36, 1'b1, 1'b0, d0);
    tick();
    start0 = 1'b1; str_len = 4'd0; c = cyc;
    tick();
    start0 = 1'b0;
    for (int k = 1; k <= 2; k++) begin
      to_cyc(c + k);
      @(negedge clk);
      chk("len0_nul", {23'd0, char_valid0, ascii_char0}, 32'h100);
    end
    to_cyc(c + 3);
    @(negedge clk);
    chk("len0_wait", {29'd0, char_valid0, busy0, done0}, 32'b010);
    at = -1;
    for (int i = 0; i < 40 && at < 0; i++) begin
      @(negedge clk);
      if (done0) at = cyc;
    end
    chk("len0_done_cyc", at, c + 19);
    chk("len0_timeout", {31'd0, timeout0}, 32'd1);
    chk("len0_pass", {31'd0, pass0}, 32'd0);
    repeat (3) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
